// File: rtl/mm_bram_pkg.sv
// Shared types and constant helpers for the BRAM limb sequencer.
package mm_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } mm_seq_state_t;

    typedef enum logic {
        CMD_LOAD  = 1'b0,
        CMD_STORE = 1'b1
    } mm_cmd_t;

    // Number of limbs per operand slot.
    function automatic int num_limbs(input int width, input int limb);
        return (width + 1) / limb + 1;
    endfunction

    // Read buffer depth: one entry per read in flight plus two of slack, so a
    // stalled consumer never loses returning data.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    // Word address to byte address shift.
    function automatic int byte_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Legal configuration: BRAM data width a power of two in 32..128 that
    // holds a whole limb, and a read latency of 1..3 cycles.
    function automatic bit params_legal(input int dw, input int limb, input int rd_lat);
        return (dw >= limb) && (dw >= 32) && (dw <= 128) && ((dw & (dw - 1)) == 0)
            && (rd_lat >= 1) && (rd_lat <= 3);
    endfunction

endpackage

// File: rtl/mm_limb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module mm_limb_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 3
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];
    assign valid   = (count != '0);

    // Storage array; contents are don't-care until counted valid.
    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mm_bram_sequencer.sv
// Moves one operand slot of limbs between a BRAM port and the multiplier core.
//
// Handshakes: a transfer happens on a clock edge where both valid and ready
// are high. start_i/start_ready_o, limb_valid_o/limb_ready_i and
// res_valid_i/res_ready_o all follow that rule; valid does not wait on ready.
module mm_bram_sequencer
    import mm_bram_pkg::*;
#(
    parameter int WIDTH       = 256,
    parameter int LIMB        = 17,
    parameter int BRAM_DW     = 32,
    parameter int BRAM_RD_LAT = 1,
    parameter int NSLOT       = 4,
    parameter int BASE_WORD   = 0
) (
    input  logic                                    clock_i,
    input  logic                                    reset_i,
    input  logic                                    start_i,
    output logic                                    start_ready_o,
    input  logic                                    cmd_store_i,
    input  logic [((NSLOT > 1) ? $clog2(NSLOT) : 1)-1:0] cmd_slot_i,
    output logic [LIMB-1:0]                         limb_o,
    output logic                                    limb_valid_o,
    input  logic                                    limb_ready_i,
    input  logic [LIMB-1:0]                         res_limb_i,
    input  logic                                    res_valid_i,
    output logic                                    res_ready_o,
    input  logic [BRAM_DW-1:0]                      BRAM_dout_i,
    output logic [BRAM_DW-1:0]                      BRAM_din_o,
    output logic [BRAM_DW/8-1:0]                    BRAM_we_o,
    output logic [31:0]                             BRAM_addr_o,
    output logic                                    BRAM_en_o,
    output logic                                    BRAM_clock_o,
    output logic                                    BRAM_reset_o,
    output logic                                    done_o,
    output logic [1:0]                              dbg_state_o
);
    localparam int S     = num_limbs(WIDTH, LIMB);
    localparam int DEPTH = fifo_depth(BRAM_RD_LAT);
    localparam int SHIFT = byte_shift(BRAM_DW);
    localparam int KW    = $clog2(S + 1);
    localparam int CW    = $clog2(DEPTH + 1);

    if (!params_legal(BRAM_DW, LIMB, BRAM_RD_LAT)) begin : g_bad_params
        $error("mm_bram_sequencer: illegal BRAM_DW / LIMB / BRAM_RD_LAT combination");
    end

    if (BRAM_DW > LIMB) begin : g_dout_hi
        logic unused_dout_hi;
        assign unused_dout_hi = ^BRAM_dout_i[BRAM_DW-1:LIMB];
    end

    mm_seq_state_t           state;
    mm_seq_state_t           state_nx;
    logic [31:0]             base_q;
    logic [31:0]             slot_word;
    logic [KW-1:0]           rd_cnt;
    logic [KW-1:0]           pop_cnt;
    logic [KW-1:0]           acc_cnt;
    logic [KW-1:0]           wr_cnt;
    logic [BRAM_RD_LAT-1:0]  rd_sr;
    logic                    wr_valid_q;
    logic [LIMB-1:0]         wr_data_q;
    logic                    issue;
    logic                    pop;
    logic                    res_fire;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_valid;
    logic [LIMB-1:0]         fifo_dout;

    // Slot index wraps modulo NSLOT; each slot spans S consecutive words.
    assign slot_word = 32'(BASE_WORD) + (32'(cmd_slot_i) % 32'(NSLOT)) * 32'(S);

    // Reads currently travelling through the BRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_RD_LAT; i++) begin
            inflight = inflight + CW'(rd_sr[i]);
        end
    end

    // Never issue more reads than the FIFO could absorb if the core stalls.
    assign issue = (state == ST_LOAD) && (rd_cnt < KW'(S))
                && (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
    assign pop      = (state == ST_LOAD) && fifo_valid && limb_ready_i;
    assign res_fire = res_ready_o && res_valid_i;

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_nx      = state;
        start_ready_o = 1'b0;
        res_ready_o   = 1'b0;
        done_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready_o = 1'b1;
                if (start_i) begin
                    state_nx = (mm_cmd_t'(cmd_store_i) == CMD_STORE) ? ST_STORE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (pop && (pop_cnt == KW'(S - 1))) begin
                    state_nx = ST_DONE;
                end
            end
            ST_STORE: begin
                res_ready_o = (acc_cnt < KW'(S));
                if (wr_valid_q && (wr_cnt == KW'(S - 1))) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Command latch, transfer counters, read-return tracker and write staging.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            base_q     <= '0;
            rd_cnt     <= '0;
            pop_cnt    <= '0;
            acc_cnt    <= '0;
            wr_cnt     <= '0;
            rd_sr      <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            if (start_i && start_ready_o) begin
                base_q  <= slot_word;
                rd_cnt  <= '0;
                pop_cnt <= '0;
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (issue)      rd_cnt  <= rd_cnt + KW'(1);
                if (pop)        pop_cnt <= pop_cnt + KW'(1);
                if (res_fire)   acc_cnt <= acc_cnt + KW'(1);
                if (wr_valid_q) wr_cnt  <= wr_cnt + KW'(1);
            end
            rd_sr[0] <= issue;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                rd_sr[i] <= rd_sr[i-1];
            end
            wr_valid_q <= res_fire;
            if (res_fire) begin
                wr_data_q <= res_limb_i;
            end
        end
    end

    mm_limb_fifo #(
        .W     (LIMB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push    (rd_sr[BRAM_RD_LAT-1]),
        .din     (BRAM_dout_i[LIMB-1:0]),
        .pop     (pop),
        .dout    (fifo_dout),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign limb_o       = fifo_dout;
    assign limb_valid_o = fifo_valid;

    // BRAM port: combinational read issue in LOAD, registered write in STORE.
    always_comb begin
        BRAM_en_o   = issue | wr_valid_q;
        BRAM_we_o   = wr_valid_q ? '1 : '0;
        BRAM_din_o  = wr_valid_q ? BRAM_DW'(wr_data_q) : '0;
        BRAM_addr_o = '0;
        if (issue) begin
            BRAM_addr_o = (base_q + 32'(rd_cnt)) << SHIFT;
        end else if (wr_valid_q) begin
            BRAM_addr_o = (base_q + 32'(wr_cnt)) << SHIFT;
        end
    end

    assign BRAM_clock_o = clock_i;
    assign BRAM_reset_o = reset_i;
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_mm_bram_sequencer.sv
// Randomised bench for mm_bram_sequencer with a behavioural transfer model.
module tb_mm_bram_sequencer;
  localparam int WIDTH = 256;
  localparam int LIMB  = 17;
  localparam int DW    = 64;
  localparam int LAT   = 3;
  localparam int NSLOT = 4;
  localparam int BASE  = 8;
  localparam int S     = (WIDTH + 1) / LIMB + 1;
  localparam int DEPTH = LAT + 2;
  localparam int BPW   = DW / 8;
  localparam int MEMW  = 128;

  // clock / reset / stimulus signals
  logic            clock_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            start_i = 1'b0;
  logic            cmd_store_i = 1'b0;
  logic [1:0]      cmd_slot_i = 2'd0;
  logic            limb_ready_i = 1'b0;
  logic [LIMB-1:0] res_limb_i = '0;
  logic            res_valid_i = 1'b0;
  logic            start_ready_o, limb_valid_o, res_ready_o;
  logic [LIMB-1:0] limb_o;
  logic [DW-1:0]   bram_dout, BRAM_din_o;
  logic [DW/8-1:0] BRAM_we_o;
  logic [31:0]     BRAM_addr_o;
  logic            BRAM_en_o, BRAM_clock_o, BRAM_reset_o, done_o;
  logic [1:0]      dbg_state;

  always #5 clock_i = ~clock_i;

  mm_bram_sequencer #(
    .WIDTH(WIDTH), .LIMB(LIMB), .BRAM_DW(DW), .BRAM_RD_LAT(LAT), .NSLOT(NSLOT), .BASE_WORD(BASE)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .start_ready_o(start_ready_o),
    .cmd_store_i(cmd_store_i), .cmd_slot_i(cmd_slot_i), .limb_o(limb_o),
    .limb_valid_o(limb_valid_o), .limb_ready_i(limb_ready_i), .res_limb_i(res_limb_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .BRAM_dout_i(bram_dout),
    .BRAM_din_o(BRAM_din_o), .BRAM_we_o(BRAM_we_o), .BRAM_addr_o(BRAM_addr_o),
    .BRAM_en_o(BRAM_en_o), .BRAM_clock_o(BRAM_clock_o), .BRAM_reset_o(BRAM_reset_o),
    .done_o(done_o), .dbg_state_o(dbg_state)
  );

  // Initial memory image; word 56 has junk above bit 16 and low limb 0x01234.
  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 56) return 64'hFFFF_FFFF_FFFE_1234;
    return {32'(i) * 32'h9E3779B1, (32'(i) * 32'h85EBCA6B) ^ 32'hDEADBEEF};
  endfunction

  // BRAM model: LAT-cycle read pipeline with junk when not reading.
  logic [DW-1:0] mem [MEMW];
  logic [DW-1:0] rd_pipe [LAT];
  int            b_cyc = 0;
  always @(posedge clock_i) begin
    b_cyc <= b_cyc + 1;
    if (b_cyc == 0) begin
      for (int i = 0; i < MEMW; i++) mem[i] <= init_word(i);
    end else if (BRAM_en_o && BRAM_we_o == '1) begin
      mem[BRAM_addr_o[9:3]] <= BRAM_din_o;
    end
    rd_pipe[0] <= (BRAM_en_o && BRAM_we_o == '0) ? mem[BRAM_addr_o[9:3]] : {$urandom, $urandom};
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_dout = rd_pipe[LAT-1];

  // scoreboard counters
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural transfer model (state for the next cycle after each update).
  logic [DW-1:0]   mem_ref [MEMW];
  logic [LIMB-1:0] exp_q[$];
  bit              m_busy = 0, m_store = 0, m_done_due = 0, m_wr_pend = 0, m_rst_chk = 0;
  bit              seen_valid = 0;
  int              m_base = 0, m_rd = 0, m_pops = 0, m_accs = 0, m_writes = 0, m_wr_word = 0;
  logic [LIMB-1:0] m_wr_data = '0;
  int              cyc = 0, acc_cyc = 0, first_valid_cyc = 0, last_pop_cyc = 0, n_done = 0;
  logic [31:0]     first_rd_addr = '0, first_wr_addr = '0;
  logic [LIMB-1:0] first_limb = '0;

  // compare process: every cycle on the falling edge
  always @(negedge clock_i) begin
    bit nd, wp;
    logic [LIMB-1:0] e;
    if (cyc == 0) begin
      for (int i = 0; i < MEMW; i++) mem_ref[i] = init_word(i);
    end
    cyc++;
    chk("bram_reset_passthru", BRAM_reset_o, reset_i);
    chk("bram_clock_passthru", BRAM_clock_o, clock_i);
    if (reset_i) begin
      m_busy = 0; m_done_due = 0; m_wr_pend = 0; m_rst_chk = 1;
      exp_q.delete();
    end else begin
      if (m_rst_chk) begin
        m_rst_chk = 0;
        chk("rst_en", BRAM_en_o, 0);       chk("rst_we", BRAM_we_o, 0);
        chk("rst_din", BRAM_din_o, 0);     chk("rst_addr", BRAM_addr_o, 0);
        chk("rst_limb_valid", limb_valid_o, 0); chk("rst_res_ready", res_ready_o, 0);
        chk("rst_done", done_o, 0);        chk("rst_start_ready", start_ready_o, 1);
        chk("rst_state", dbg_state, 0);
      end
      nd = 0; wp = 0;
      chk("done", done_o, m_done_due);
      if (done_o) n_done++;
      chk("start_ready", start_ready_o, !m_busy);
      chk("res_ready", res_ready_o, m_busy && m_store && (m_accs < S));
      // writes must appear exactly one cycle after each accepted result limb
      if (m_wr_pend) begin
        chk("wr_en", BRAM_en_o, 1);
        chk("wr_we", BRAM_we_o, 8'hFF);
        chk("wr_addr", BRAM_addr_o, 64'(m_wr_word * BPW));
        chk("wr_din", BRAM_din_o, {47'b0, m_wr_data});
        if (m_writes == 0) first_wr_addr = BRAM_addr_o;
        mem_ref[m_wr_word] = {47'b0, m_wr_data};
        m_writes++;
        if (m_writes == S) nd = 1;
      end else begin
        chk("no_write", BRAM_we_o, 0);
      end
      // reads: in order, only during a load, bounded outstanding count
      if (BRAM_en_o && BRAM_we_o == '0) begin
        chk("rd_in_load", m_busy && !m_store && !m_done_due, 1);
        chk("rd_addr", BRAM_addr_o, 64'((m_base + m_rd) * BPW));
        if (m_rd == 0) first_rd_addr = BRAM_addr_o;
        m_rd++;
        chk("rd_count_limit", m_rd <= S, 1);
        chk("outstanding_le_depth", (m_rd - m_pops) <= DEPTH, 1);
      end
      // delivered limbs against the expected queue
      if (limb_valid_o) begin
        chk("valid_has_data", exp_q.size() > 0, 1);
        if (!seen_valid) begin seen_valid = 1; first_valid_cyc = cyc; end
      end
      if (limb_valid_o && limb_ready_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("limb", limb_o, e);
        if (m_pops == 0) first_limb = limb_o;
        m_pops++;
        last_pop_cyc = cyc;
        if (m_pops == S) nd = 1;
      end
      if (m_busy && m_store && (m_accs < S) && res_valid_i) begin
        wp = 1;
        m_wr_word = m_base + m_accs;
        m_wr_data = res_limb_i;
        m_accs++;
      end
      if (!m_busy && start_i) begin
        m_busy = 1; m_store = cmd_store_i;
        m_base = BASE + (int'(cmd_slot_i) % NSLOT) * S;
        m_rd = 0; m_pops = 0; m_accs = 0; m_writes = 0;
        acc_cyc = cyc; seen_valid = 0;
        if (!cmd_store_i) begin
          for (int k = 0; k < S; k++) exp_q.push_back(mem_ref[m_base + k][LIMB-1:0]);
        end
      end else if (m_done_due) begin
        m_busy = 0;
      end
      m_done_due = nd;
      m_wr_pend = wp;
    end
  end

  // driver: one command, randomised handshakes, optional start noise / reset
  task automatic do_cmd(input bit store, input int slot, input int rdy_pct, input int vld_pct,
                        input bit pattern, input bit noise, input int rst_after);
    int guard;
    @(posedge clock_i); #1;
    start_i = 1'b1; cmd_store_i = store; cmd_slot_i = 2'(slot);
    guard = 0;
    while (!m_busy && guard < 50) begin
      @(posedge clock_i); #1;
      guard++;
    end
    chk("accept_seen", m_busy, 1);
    start_i = 1'b0;
    guard = 0;
    while (m_busy && guard < 3000) begin
      limb_ready_i = ($urandom_range(99) < rdy_pct);
      res_valid_i  = ($urandom_range(99) < vld_pct);
      res_limb_i   = pattern ? (17'h1FFFF - 17'(m_accs)) : 17'($urandom);
      reset_i      = (rst_after > 0) && (m_pops >= rst_after);
      start_i      = noise && !reset_i && ($urandom_range(4) == 0);
      cmd_store_i  = 1'($urandom);
      cmd_slot_i   = 2'($urandom);
      @(posedge clock_i); #1;
      guard++;
    end
    chk("cmd_completes", m_busy, 0);
    reset_i = 1'b0; start_i = 1'b0; limb_ready_i = 1'b0; res_valid_i = 1'b0;
  endtask

  initial begin
    int n_cmds;
    repeat (3) @(posedge clock_i);
    #1 reset_i = 1'b0;
    repeat (2) @(posedge clock_i);

    // LOAD slot 3, consumer always ready
    do_cmd(0, 3, 100, 0, 0, 0, 0);
    chk("load_first_addr", first_rd_addr, 448);
    chk("load_first_limb", first_limb, 17'h01234);
    chk("load_valid_latency", first_valid_cyc - acc_cyc, LAT + 2);
    chk("load_burst_span", last_pop_cyc - first_valid_cyc, S - 1);
    chk("done_after_load", n_done, 1);

    // STORE slot 1 with limbs 0x1FFFF-k, producer always valid
    do_cmd(1, 1, 0, 100, 1, 0, 0);
    chk("store_first_addr", first_wr_addr, (BASE + S) * BPW);
    chk("done_after_store", n_done, 2);

    // read the stored slot back under a 30% ready duty with start noise
    do_cmd(0, 1, 30, 0, 0, 1, 0);
    chk("readback_first_limb", first_limb, 17'h1FFFF);
    n_cmds = 3;

    // random mix of commands
    for (int i = 0; i < 6; i++) begin
      do_cmd(1'($urandom), $urandom_range(3), $urandom_range(20, 100), $urandom_range(20, 100),
             0, 1, 0);
      n_cmds++;
    end

    // reset after 5 limbs, then a fresh load of the same slot
    do_cmd(0, 2, 60, 0, 0, 0, 5);
    repeat (LAT + 3) @(posedge clock_i);
    do_cmd(0, 2, 100, 0, 0, 0, 0);
    n_cmds++;
    chk("fresh_load_first_addr", first_rd_addr, (BASE + 2 * S) * BPW);
    chk("done_pulse_count", n_done, n_cmds);

    repeat (4) @(posedge clock_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_bram_sequencer.md
# mm_bram_sequencer

Parametrised BRAM limb transfer engine for the FIOS Montgomery multiplier. It moves `s` operand limbs between a Block RAM master port and the multiplier core. LOAD commands stream limbs from BRAM into the core; STORE commands write result limbs from the core back to BRAM. Compared with the fixed 32-bit, single-latency BRAM glue, it adds configurable BRAM data width, read latency, limb width and operand slots, plus valid/ready flow control with a latency-tolerant read buffer.

## Interface
Parameters:
- `WIDTH`, 256: operand bit width.
- `LIMB`, 17: limb width; `s = (WIDTH+1)/LIMB + 1`, localparam.
- `BRAM_DW`, 32: BRAM data width; power of two, 32..128, ≥ LIMB.
- `BRAM_RD_LAT`, 1: BRAM read latency in cycles, 1..3.
- `NSLOT`, 4: number of operand slots.
- `BASE_WORD`, 0: word address of slot 0.

Ports:
- `clock_i` in 1: clock. One clock; reset is synchronous and active-high.
- `reset_i` in 1: synchronous, active-high reset.
- `start_i` in 1: command valid.
- `start_ready_o` out 1: command accepted when `start_i & start_ready_o`.
- `cmd_store_i` in 1: 0 = LOAD, 1 = STORE.
- `cmd_slot_i` in clog2(NSLOT): slot index.
- `limb_o` out LIMB: load limb to core.
- `limb_valid_o` out 1: load limb valid.
- `limb_ready_i` in 1: core accepts load limb.
- `res_limb_i` in LIMB: result limb from core.
- `res_valid_i` in 1: result limb valid.
- `res_ready_o` out 1: engine accepts result limb.
- `BRAM_dout_i` in BRAM_DW: BRAM read data.
- `BRAM_din_o` out BRAM_DW: BRAM write data.
- `BRAM_we_o` out BRAM_DW/8: byte write enables.
- `BRAM_addr_o` out 32: byte address.
- `BRAM_en_o` out 1: BRAM enable.
- `BRAM_clock_o` out 1: equals `clock_i`.
- `BRAM_reset_o` out 1: equals `reset_i`.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, STORE, DONE.
  - IDLE → LOAD or STORE on accepted start.
  - LOAD → DONE after the s-th limb handshake.
  - STORE → DONE after the s-th BRAM write cycle.
  - DONE → IDLE unconditionally.
- `start_ready_o` = (state == IDLE). A start outside IDLE is ignored, with no side effects.
- Command slot and type are latched at accept.
  - Word address for limb k = BASE_WORD + slot·s + k.
  - `BRAM_addr_o` = word address << log2(BRAM_DW/8).
  - Slot index ≥ NSLOT wraps modulo NSLOT.
- LOAD path:
  - Reads are issued in order k = 0..s-1: `BRAM_en_o` = 1, `BRAM_we_o` = 0.
  - Issue only while (in-flight reads + FIFO occupancy) < DEPTH, with DEPTH = BRAM_RD_LAT + 2. This guarantees no overflow under arbitrary `limb_ready_i` stalls.
  - Returning data is tracked by a BRAM_RD_LAT-deep valid shift register. `BRAM_dout_i[LIMB-1:0]` is pushed into the FIFO; upper bits are ignored.
  - `limb_o` and `limb_valid_o` are the FIFO head (first-word fall-through).
- STORE path:
  - `res_ready_o` = 1 in STORE while the accepted count < s.
  - An accepted limb produces a registered write next cycle: `BRAM_en_o` = 1, `BRAM_we_o` = all ones, `BRAM_din_o` = zero-extended limb.
- Reset mid-operation: state → IDLE, counters cleared, FIFO flushed, valid shift register cleared. Read data returning after reset is discarded.

## Timing
- Reset values: `BRAM_en_o`, `BRAM_we_o`, `BRAM_din_o`, `BRAM_addr_o`, `limb_valid_o`, `res_ready_o`, `done_o` are all 0. `start_ready_o` is 1 in the first cycle after the reset edge.
- LOAD, with start accepted at edge E0:
  - First read address is presented in cycle E0+1.
  - Data is captured at edge E0+1+BRAM_RD_LAT.
  - `limb_valid_o` is first high in cycle E0+2+BRAM_RD_LAT.
  - With `limb_ready_i` held high: one limb per cycle, s consecutive cycles.
- `done_o` timing:
  - LOAD: pulse in the cycle after the final limb handshake.
  - STORE: pulse in the cycle after the final write cycle.
  - `start_ready_o` returns in the cycle after the `done_o` pulse.
- STORE with `res_valid_i` held high: s accepts in s cycles, then s writes, each lagging its accept by one cycle.
- A simultaneous FIFO push and pop keeps occupancy unchanged.

## Structure
- Package `mm_bram_pkg`:
  - state enum `mm_seq_state_t`;
  - command enum (`CMD_LOAD`, `CMD_STORE`);
  - `DEPTH` and byte-shift constant functions;
  - parameter-legality checks (BRAM_DW ≥ LIMB, BRAM_RD_LAT in 1..3).
- Sub-module `mm_limb_fifo`: synchronous first-word-fall-through FIFO, parameters W and DEPTH, with count output.

## Test plan
- Defaults (s = 16). LOAD slot 2, `limb_ready_i` = 1, memory word n = n: addresses 0x80, 0x84, …, 0xBC. Limbs 32..47 appear on 16 consecutive cycles starting E0+3. `done_o` fires once.
- STORE slot 1 with limbs 0x1FFFF − k: 16 writes at byte addresses 0x40..0x7C, `BRAM_we_o` = 0xF, `BRAM_din_o` upper 15 bits zero.
- BRAM_RD_LAT = 3, random `limb_ready_i` at 30% duty: all 16 limbs delivered in order, with no loss and no duplication. Outstanding + occupancy never exceeds 5.
- BRAM_DW = 64, BASE_WORD = 8, slot 3: first byte address (8 + 48)·8 = 448. `BRAM_dout_i` bits above 16 are ignored.
- `start_i` asserted during LOAD: ignored, and the transfer is unaffected.
- `reset_i` asserted after 5 limbs of a LOAD: outputs take their reset values the next cycle. Stale read data is not delivered. A fresh LOAD then completes correctly.
